// File: rtl/matrix_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_scan_controller
//  Purpose  : LED dot-matrix scan sequencer. Walks a one-hot row drive through
//             ROWS rows with a DIV+1 cycle dwell, separated by BLANK_CYC dark
//             cycles to suppress ghosting. Column data comes from a
//             double-buffered frame store; the back bank is written by the
//             CPU side and swapped with the front bank only at a frame
//             boundary, so no frame is ever displayed half old / half new.
//  Ports    : clk         - system clock, rising edge
//             rst         - synchronous active-high reset
//             we          - back-bank write strobe
//             waddr       - row address of write (ignored when >= ROWS)
//             wdata       - column pattern for row waddr
//             swap_req    - level request to swap front/back banks
//             swap_ack    - one-cycle pulse, swap performed
//             row_out     - one-hot row drive, zero while blanking
//             col_out     - column drive, zero while blanking
//             frame_start - pulse on first drive cycle of row 0
//  Revision : 1.0 - initial release
// ============================================================================
module matrix_scan_controller #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int DIV       = 2000,
  parameter int BLANK_CYC = 16,
  parameter int AW        = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [COLS-1:0] wdata,
  input  logic            swap_req,
  output logic            swap_ack,
  output logic [ROWS-1:0] row_out,
  output logic [COLS-1:0] col_out,
  output logic            frame_start
);

  // Counter widths sized so DIV=0 / BLANK_CYC=1 still give at least one bit.
  localparam int DW = $clog2(DIV + 2);
  localparam int BW = $clog2(BLANK_CYC + 1);

  localparam logic [DW-1:0] DWELL_LAST = DW'(DIV);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);
  localparam logic [AW-1:0] ROW_LAST   = AW'(ROWS - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   row, row_nxt;
  logic [BW-1:0]   blank_cnt, blank_nxt;
  logic [DW-1:0]   dwell_cnt, dwell_nxt;
  logic            front, front_nxt;
  logic [ROWS-1:0] row_out_nxt;
  logic [COLS-1:0] col_out_nxt;
  logic            swap_ack_nxt;
  logic            frame_start_nxt;

  // bank[front] is displayed; bank[~front] is the CPU-writable back bank.
  logic [COLS-1:0] bank [2][ROWS];
  logic            wr_ok;

  assign wr_ok = ({{(32-AW){1'b0}}, waddr} < 32'(ROWS));

  // --------------------------------------------------------------------------
  // Frame store. A write on the swap edge uses the pre-swap front index, so
  // it lands in the bank that is about to become the front.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          bank[b][r] <= '0;
        end
      end
    end else if (we && wr_ok) begin
      bank[~front][waddr] <= wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_BLANK;
      row         <= '0;
      blank_cnt   <= '0;
      dwell_cnt   <= '0;
      front       <= 1'b0;
      row_out     <= '0;
      col_out     <= '0;
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      row         <= row_nxt;
      blank_cnt   <= blank_nxt;
      dwell_cnt   <= dwell_nxt;
      front       <= front_nxt;
      row_out     <= row_out_nxt;
      col_out     <= col_out_nxt;
      swap_ack    <= swap_ack_nxt;
      frame_start <= frame_start_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and registered-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt       = state;
    row_nxt         = row;
    blank_nxt       = blank_cnt;
    dwell_nxt       = dwell_cnt;
    front_nxt       = front;
    row_out_nxt     = row_out;
    col_out_nxt     = col_out;
    swap_ack_nxt    = 1'b0;
    frame_start_nxt = 1'b0;

    case (state)
      ST_BLANK: begin
        row_out_nxt = '0;
        col_out_nxt = '0;
        if (blank_cnt == BLANK_LAST) begin
          // Column data is captured once here and held for the whole dwell,
          // so later writes or swaps cannot disturb the row being shown.
          state_nxt       = ST_DRIVE;
          dwell_nxt       = '0;
          row_out_nxt     = ROWS'(1) << row;
          col_out_nxt     = bank[front][row];
          frame_start_nxt = (row == '0);
        end else begin
          blank_nxt = blank_cnt + 1'b1;
        end
      end

      ST_DRIVE: begin
        if (dwell_cnt == DWELL_LAST) begin
          state_nxt   = ST_BLANK;
          blank_nxt   = '0;
          row_out_nxt = '0;
          col_out_nxt = '0;
          if (row == ROW_LAST) begin
            row_nxt = '0;
            // Leaving the last row is the only tear-free swap point.
            if (swap_req) begin
              front_nxt    = ~front;
              swap_ack_nxt = 1'b1;
            end
          end else begin
            row_nxt = row + 1'b1;
          end
        end else begin
          dwell_nxt = dwell_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = ST_BLANK;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matrix_scan_controller
//  Purpose  : Directed self-checking bench for matrix_scan_controller with
//             ROWS=4, COLS=4, DIV=3, BLANK_CYC=2 (row period 6, frame 24).
//             Time t counts cycles since the last reset edge; row r of frame
//             k drives at t = 2 + 24k + 6r .. +3, swap acks appear at 24k+24.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_scan_controller;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            we = 1'b0;
  logic [1:0]      waddr = '0;
  logic [COLS-1:0] wdata = '0;
  logic            swap_req = 1'b0;
  logic            swap_ack;
  logic [ROWS-1:0] row_out;
  logic [COLS-1:0] col_out;
  logic            frame_start;

  int checks = 0;
  int errors = 0;
  int tnow   = 0;

  matrix_scan_controller #(
    .ROWS(4), .COLS(4), .DIV(3), .BLANK_CYC(2), .AW(2)
  ) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .swap_req(swap_req), .swap_ack(swap_ack), .row_out(row_out),
    .col_out(col_out), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    tnow++;
  endtask

  task automatic run_to(input int t);
    while (tnow < t) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; we = 1'b0; swap_req = 1'b0;
    step(); step();
    rst = 1'b0;
    tnow = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({row_out, col_out, swap_ack, frame_start} !== 10'd0) begin
      errors++; $display("FAIL reset_outs t=%0d got %b exp 0", tnow, {row_out, col_out, swap_ack, frame_start}); end
    step();
    checks++; if (row_out !== 4'b0000 || col_out !== 4'b0000) begin
      errors++; $display("FAIL blank2 t=%0d row %b col %b exp 0000/0000", tnow, row_out, col_out); end
    step();
    checks++; if (row_out !== 4'b0001 || col_out !== 4'b0000 || frame_start !== 1'b1) begin
      errors++; $display("FAIL first_drive row %b col %b fs %b exp 0001/0000/1", row_out, col_out, frame_start); end
    run_to(5);
    checks++; if (row_out !== 4'b0001 || frame_start !== 1'b0) begin
      errors++; $display("FAIL dwell_end row %b fs %b exp 0001/0", row_out, frame_start); end
    step();
    checks++; if (row_out !== 4'b0000) begin
      errors++; $display("FAIL blank_a row %b exp 0000", row_out); end
    step();
    checks++; if (row_out !== 4'b0000) begin
      errors++; $display("FAIL blank_b row %b exp 0000", row_out); end
    step();
    checks++; if (row_out !== 4'b0010) begin
      errors++; $display("FAIL row1 row %b exp 0010", row_out); end
  endtask

  task automatic test_free_run();
    logic [ROWS-1:0] exp_row;
    logic            exp_fs;
    int p, r;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      step();
      p = (tnow - 2) % 6;
      r = ((tnow - 2) / 6) % 4;
      exp_row = (tnow >= 2 && p < 4) ? (4'b0001 << r) : 4'b0000;
      exp_fs  = (tnow >= 2 && p == 0 && r == 0);
      checks++; if (row_out !== exp_row || frame_start !== exp_fs) begin
        errors++; $display("FAIL free_run t=%0d row %b fs %b exp %b/%b", tnow, row_out, frame_start, exp_row, exp_fs); end
    end
  endtask

  task automatic test_swap();
    do_reset();
    we = 1'b1; waddr = 2'd0; wdata = 4'hA; step();
    waddr = 2'd1; wdata = 4'h5; step();
    waddr = 2'd2; wdata = 4'hF; step();
    waddr = 2'd3; wdata = 4'h1; step();
    we = 1'b0;
    run_to(8);
    checks++; if (row_out !== 4'b0010 || col_out !== 4'h0) begin
      errors++; $display("FAIL no_swap_col row %b col %h exp 0010/0", row_out, col_out); end
    swap_req = 1'b1;
    while (tnow < 23) begin
      step();
      checks++; if (swap_ack !== 1'b0 || col_out !== 4'h0) begin
        errors++; $display("FAIL early_ack t=%0d ack %b col %h exp 0/0", tnow, swap_ack, col_out); end
    end
    step();
    checks++; if (swap_ack !== 1'b1 || row_out !== 4'b0000) begin
      errors++; $display("FAIL ack t=%0d ack %b row %b exp 1/0000", tnow, swap_ack, row_out); end
    swap_req = 1'b0;
    step();
    checks++; if (swap_ack !== 1'b0) begin
      errors++; $display("FAIL ack_pulse ack %b exp 0", swap_ack); end
    run_to(26);
    checks++; if (row_out !== 4'b0001 || col_out !== 4'hA) begin
      errors++; $display("FAIL swapped_r0 row %b col %h exp 0001/A", row_out, col_out); end
    run_to(29);
    checks++; if (col_out !== 4'hA) begin
      errors++; $display("FAIL hold_r0 col %h exp A", col_out); end
    run_to(32);
    checks++; if (col_out !== 4'h5) begin
      errors++; $display("FAIL swapped_r1 col %h exp 5", col_out); end
    run_to(38);
    checks++; if (row_out !== 4'b0100 || col_out !== 4'hF) begin
      errors++; $display("FAIL swapped_r2 row %b col %h exp 0100/F", row_out, col_out); end
  endtask

  // Continues the timeline left by test_swap (front bank = A,5,F,1).
  task automatic test_write_in_row();
    we = 1'b1; waddr = 2'd2; wdata = 4'h3; step();
    we = 1'b0;
    checks++; if (col_out !== 4'hF) begin
      errors++; $display("FAIL write_in_row col %h exp F", col_out); end
    run_to(40);
    we = 1'b1; waddr = 2'd3; wdata = 4'h6; step();
    we = 1'b0;
    run_to(44);
    checks++; if (row_out !== 4'b1000 || col_out !== 4'h1) begin
      errors++; $display("FAIL r3_front row %b col %h exp 1000/1", row_out, col_out); end
    run_to(48);
    checks++; if (swap_ack !== 1'b0) begin
      errors++; $display("FAIL no_req_ack ack %b exp 0", swap_ack); end
    run_to(62);
    checks++; if (col_out !== 4'hF) begin
      errors++; $display("FAIL front_r2 col %h exp F", col_out); end
    swap_req = 1'b1;
    run_to(72);
    checks++; if (swap_ack !== 1'b1) begin
      errors++; $display("FAIL ack2 ack %b exp 1", swap_ack); end
    swap_req = 1'b0;
    run_to(74);
    checks++; if (col_out !== 4'h0) begin
      errors++; $display("FAIL back_r0 col %h exp 0", col_out); end
    run_to(86);
    checks++; if (col_out !== 4'h3) begin
      errors++; $display("FAIL back_r2 col %h exp 3", col_out); end
    run_to(92);
    checks++; if (row_out !== 4'b1000 || col_out !== 4'h6) begin
      errors++; $display("FAIL back_r3 row %b col %h exp 1000/6", row_out, col_out); end
  endtask

  task automatic test_reset_mid();
    run_to(110);
    checks++; if (row_out !== 4'b0100 || col_out !== 4'h3) begin
      errors++; $display("FAIL pre_reset row %b col %h exp 0100/3", row_out, col_out); end
    swap_req = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; swap_req = 1'b0; tnow = 0;
    checks++; if ({row_out, col_out, swap_ack, frame_start} !== 10'd0) begin
      errors++; $display("FAIL mid_reset got %b exp 0", {row_out, col_out, swap_ack, frame_start}); end
    while (tnow < 30) begin
      step();
      checks++; if (swap_ack !== 1'b0) begin
        errors++; $display("FAIL reset_ack t=%0d ack %b exp 0", tnow, swap_ack); end
      if (tnow == 2 || tnow == 14) begin
        checks++; if (col_out !== 4'h0 || row_out !== (tnow == 2 ? 4'b0001 : 4'b0100)) begin
          errors++; $display("FAIL cleared t=%0d row %b col %h", tnow, row_out, col_out); end
      end
    end
  endtask

  task automatic test_swap_hold();
    int acks = 0;
    logic exp_ack;
    do_reset();
    swap_req = 1'b1;
    we = 1'b1; waddr = 2'd0; wdata = 4'h1; step();
    waddr = 2'd1; wdata = 4'h2; step();
    waddr = 2'd2; wdata = 4'h4; step();
    waddr = 2'd3; wdata = 4'h8; step();
    we = 1'b0;
    while (tnow < 80) begin
      step();
      exp_ack = (tnow == 24 || tnow == 48 || tnow == 72);
      if (swap_ack === 1'b1) acks++;
      checks++; if (swap_ack !== exp_ack) begin
        errors++; $display("FAIL hold_ack t=%0d ack %b exp %b", tnow, swap_ack, exp_ack); end
      if (tnow == 26 || tnow == 32 || tnow == 50 || tnow == 74) begin
        checks++; if (col_out !== (tnow == 26 ? 4'h1 : tnow == 32 ? 4'h2 : tnow == 50 ? 4'h0 : 4'h1)) begin
          errors++; $display("FAIL alt_bank t=%0d col %h", tnow, col_out); end
      end
    end
    swap_req = 1'b0;
    checks++; if (acks != 3) begin
      errors++; $display("FAIL ack_count got %0d exp 3", acks); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_swap();
    test_write_in_row();
    test_reset_mid();
    test_swap_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matrix_scan_controller.md
Name: matrix_scan_controller

Overview:
Sequences the LED dot-matrix display: steps one-hot row drive through ROWS rows at a programmable dwell, inserts a blanking gap between rows to suppress ghosting, and drives column data from a double-buffered frame store. The CPU/debug side writes the back bank and requests a tear-free bank swap, which commits only at a frame boundary. The block replaces a free-running divided matrix clock with an in-domain scan sequencer; everything runs on the system clock.

Parameters:
ROWS, 8, number of matrix rows (>=2)
COLS, 8, number of matrix columns
DIV, 2000, row dwell: each row is driven for exactly DIV+1 cycles
BLANK_CYC, 16, blanking cycles between rows (>=1)
AW, 3, row address width; must satisfy 2**AW >= ROWS

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous, active-high reset
WE  in  1  write strobe for back bank
WADDR  in  AW  row address of write
WDATA  in  COLS  column pattern for row WADDR, bit i = column i lit
SWAP_REQ  in  1  level request to swap front/back banks
SWAP_ACK  out  1  one-cycle pulse, swap performed
ROW_OUT  out  ROWS  one-hot active-high row drive, all-zero while blanking
COL_OUT  out  COLS  active-high column drive, zero while blanking
FRAME_START  out  1  one-cycle pulse on first DRIVE cycle of row 0

Behaviour:
- Reset (sampled high at any edge, including mid-row or mid-swap): ROW_OUT=0, COL_OUT=0, SWAP_ACK=0, FRAME_START=0; both banks cleared to 0; front bank index=0; state=BLANK, row=0, blank counter=0, dwell counter=0. A pending SWAP_REQ is discarded.
- All outputs are registered.
- FSM states: BLANK, DRIVE.
- BLANK: ROW_OUT=0, COL_OUT=0; lasts exactly BLANK_CYC cycles. After reset release, the first cycle with RST low is BLANK cycle 1.
- BLANK->DRIVE: ROW_OUT=one-hot(row), COL_OUT=front_bank[row] latched at entry. Both stay constant for the whole dwell; writes and swaps never alter a row in progress. The dwell counter restarts at 0 on entry. FRAME_START=1 on this cycle iff row==0.
- DRIVE lasts DIV+1 cycles (counter 0..DIV). At counter==DIV the next state is BLANK and row increments, wrapping ROWS-1 -> 0.
- Row period=DIV+1+BLANK_CYC; frame period=ROWS*(DIV+1+BLANK_CYC).
- Writes: at an edge with WE=1 and WADDR<ROWS, back_bank[WADDR]<=WDATA. WADDR>=ROWS is ignored. Writes never touch the front bank.
- Swap: swap boundary = the edge leaving DRIVE of row ROWS-1. If SWAP_REQ=1 at that edge, the front index toggles, and SWAP_ACK=1 for the following cycle only. The requester deasserts SWAP_REQ after seeing ACK. If SWAP_REQ stays high, a swap occurs at every frame boundary.
- A write sampled on the same edge as a swap lands in the pre-swap back bank (the new front). Software must not write between request and ACK.
- No swap occurs at reset or before the first complete frame.

Test Plan:
(Parameters: ROWS=4, COLS=4, DIV=3, BLANK_CYC=2, AW=2.)
1. Reset then release -> 2 cycles ROW_OUT=0000/COL_OUT=0000. Then ROW_OUT=0001, COL_OUT=0000 and FRAME_START=1 for one cycle. Row held 4 cycles, 2 blank cycles, then ROW_OUT=0010.
2. Free run -> row order 0001,0010,0100,1000,0001. FRAME_START pulses exactly 24 cycles apart. No cycle has two ROW_OUT bits set.
3. Write back rows 0..3 = A,5,F,1 with no swap -> COL_OUT stays 0. Raise SWAP_REQ during row 1 -> SWAP_ACK single pulse in the cycle after row-3 DRIVE ends. Next frame COL_OUT = A,5,F,1 per row.
4. Write WADDR=2 while row 2 is driving (post-swap front) -> COL_OUT unchanged. WE with WADDR=3 lands only in the back bank, visible only after the next swap.
5. Assert RST for 1 cycle during row 2 DRIVE with SWAP_REQ high -> next cycle all outputs 0, no ACK. Restart shows row 0 with COL_OUT=0 (banks cleared).
6. Hold SWAP_REQ high for 3 frames -> 3 ACK pulses, one per frame boundary. Displayed bank alternates each frame.
